// File: rtl/uart_reg_responder.sv
// Byte-command register responder between a UART receiver and transmitter.
// Optional inter-byte write timeout is enabled by defining UART_REG_RESP_TIMEOUT_EN.
module uart_reg_responder #(
  parameter int                      WIDTH_DATA     = 8,
  parameter int                      NUM_REGS       = 16,
  parameter logic [WIDTH_DATA-1:0]   ACK_BYTE       = 8'hA5,
  parameter logic [WIDTH_DATA-1:0]   NAK_BYTE       = 8'h5A,
  parameter int                      TIMEOUT_CYCLES = 1024
) (
  input  logic                           i_clk,
  input  logic                           i_reset_n,
  input  logic [WIDTH_DATA-1:0]          iv_rx_data,
  input  logic                           i_rx_data_ready,
  output logic [WIDTH_DATA-1:0]          ov_tx_data,
  output logic                           o_tx_data_ready,
  input  logic                           i_tx_busy,
  output logic [NUM_REGS*WIDTH_DATA-1:0] ov_regs,
  output logic                           o_overrun,
  output logic                           o_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    SEND      = 2'd2,
    WAIT_TX   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH_DATA-1:0] r_regs [NUM_REGS];
  logic [WIDTH_DATA-1:0] r_tx_data;
  logic [WIDTH_DATA-1:0] w_tx_next;
  logic [WIDTH_DATA-1:0] w_rd_data;
  logic [3:0]            r_addr;
  logic [3:0]            w_addr;
  logic                  w_cmd_ok;
  logic                  w_wr_en;
  logic                  w_timeout;
  logic                  r_busy_seen;
  logic                  r_overrun;

  assign w_addr   = iv_rx_data[3:0];
  assign w_cmd_ok = (iv_rx_data[6:4] == 3'd0) && (32'(w_addr) < NUM_REGS);

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_addr == 4'(k)) w_rd_data = r_regs[k];
    end
  end

`ifdef UART_REG_RESP_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                r_cnt <= '0;
    else if (r_state != WAIT_DATA) r_cnt <= '0;
    else                           r_cnt <= r_cnt + 1'b1;
  end
`endif

  always_comb begin
    w_state_next    = r_state;
    w_tx_next       = r_tx_data;
    w_wr_en         = 1'b0;
    w_timeout       = 1'b0;
    o_tx_data_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_data_ready) begin
          if (!w_cmd_ok) begin
            w_tx_next    = NAK_BYTE;
            w_state_next = SEND;
          end else if (iv_rx_data[7]) begin
            w_state_next = WAIT_DATA;
          end else begin
            w_tx_next    = w_rd_data;
            w_state_next = SEND;
          end
        end
      end
      WAIT_DATA: begin
        // A data byte in the last counted cycle takes priority over the timeout.
        if (i_rx_data_ready) begin
          w_wr_en      = 1'b1;
          w_tx_next    = ACK_BYTE;
          w_state_next = SEND;
        end
`ifdef UART_REG_RESP_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
`endif
      end
      SEND: begin
        if (!i_tx_busy) begin
          o_tx_data_ready = 1'b1;
          w_state_next    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (r_busy_seen && !i_tx_busy) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_tx_data   <= '0;
      r_addr      <= '0;
      r_busy_seen <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_tx_data <= w_tx_next;
      if (r_state == IDLE && i_rx_data_ready) r_addr <= w_addr;
      // Busy must be observed high before its falling edge ends the transfer.
      if (r_state != WAIT_TX) r_busy_seen <= 1'b0;
      else if (i_tx_busy)     r_busy_seen <= 1'b1;
      if (i_rx_data_ready && (r_state == SEND || r_state == WAIT_TX)) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_en && r_addr == 4'(k)) r_regs[k] <= iv_rx_data;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign ov_regs[gi*WIDTH_DATA +: WIDTH_DATA] = r_regs[gi];
    end
  endgenerate

  assign ov_tx_data = r_tx_data;
  assign o_overrun  = r_overrun;
  assign o_timeout  = w_timeout;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Scoreboard bench for uart_reg_responder: expected tx bytes are queued at stimulus
// time and popped by an independent monitor on every o_tx_data_ready strobe.
module tb_uart_reg_responder;
  localparam int NREG = 4;

  logic            clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_rdy = 1'b0;
  logic [7:0]      tx_data;
  logic            tx_rdy;
  logic            tx_busy;
  logic            tx_busy_m = 1'b0;
  logic            hold_busy = 1'b0;
  logic [NREG*8-1:0] regs;
  logic            overrun;
  logic            timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  assign tx_busy = tx_busy_m | hold_busy;

  uart_reg_responder #(
    .WIDTH_DATA(8), .NUM_REGS(NREG), .ACK_BYTE(8'hA5), .NAK_BYTE(8'h5A), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .iv_rx_data(rx_data), .i_rx_data_ready(rx_rdy),
    .ov_tx_data(tx_data), .o_tx_data_ready(tx_rdy), .i_tx_busy(tx_busy),
    .ov_regs(regs), .o_overrun(overrun), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Transmitter model: goes busy for 4 cycles after each load strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_rdy) begin
        @(posedge clk); #1 tx_busy_m = 1'b1;
        repeat (4) @(posedge clk);
        #1 tx_busy_m = 1'b0;
      end
    end
  end

  // Monitor: every strobe must match the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_rdy && i_reset_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_tx", {56'd0, tx_data}, 64'hDEAD);
        end else begin
          check("tx_byte", {56'd0, tx_data}, {56'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_rdy  = 1'b1;
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 200) begin @(posedge clk); cyc++; end
    repeat (2) @(posedge clk);
    while (tx_busy && cyc < 200) begin @(posedge clk); cyc++; end
    if (cyc >= 200) check("wait_bound", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int first_k;
    int pulses;
    repeat (3) @(posedge clk);
    #1;
    check("reset_regs", {32'd0, regs}, 64'd0);
    check("reset_tx_data", {56'd0, tx_data}, 64'd0);
    check("reset_tx_rdy", {63'd0, tx_rdy}, 64'd0);
    check("reset_overrun", {63'd0, overrun}, 64'd0);
    check("reset_timeout", {63'd0, timeout}, 64'd0);
    @(posedge clk); #1 i_reset_n = 1'b1;

    // Write reg3 = 0x5C
    exp_q.push_back(8'hA5);
    send_byte(8'h83);
    send_byte(8'h5C);
    wait_done();
    check("write_reg3", {32'd0, regs}, 64'h5C00_0000);

    // Read reg3, with first-cycle latency check
    exp_q.push_back(8'h5C);
    send_byte(8'h03);
    @(negedge clk);
    check("read_latency", {63'd0, tx_rdy}, 64'd1);
    wait_done();
    check("read_no_change", {32'd0, regs}, 64'h5C00_0000);

    // Nonzero bits 6:4
    exp_q.push_back(8'h5A);
    send_byte(8'h15);
    wait_done();

    // Out-of-range write: no data consumed, next byte is a read of reg2
    exp_q.push_back(8'h5A);
    send_byte(8'h86);
    wait_done();
    exp_q.push_back(8'h00);
    send_byte(8'h02);
    wait_done();
    check("nak_no_change", {32'd0, regs}, 64'h5C00_0000);

    // Write reg0 = 0x11, read it back
    exp_q.push_back(8'hA5);
    send_byte(8'h80);
    send_byte(8'h11);
    wait_done();
    exp_q.push_back(8'h11);
    send_byte(8'h00);
    wait_done();
    check("write_reg0", {32'd0, regs}, 64'h5C00_0011);
    check("overrun_clear", {63'd0, overrun}, 64'd0);

    // Backpressure: second byte arrives in SEND and is dropped
    hold_busy = 1'b1;
    exp_q.push_back(8'h11);
    send_byte(8'h00);
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("busy_hold_quiet", {63'd0, tx_rdy}, 64'd0);
    end
    @(posedge clk); #1 hold_busy = 1'b0;
    wait_done();
    check("overrun_set", {63'd0, overrun}, 64'd1);
    check("overrun_no_write", {32'd0, regs}, 64'h5C00_0011);

    // Write to reg1 with no data byte
    send_byte(8'h81);
    first_k = 0;
    pulses  = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (timeout) begin
        pulses++;
        if (first_k == 0) first_k = k;
      end
    end
`ifdef UART_REG_RESP_TIMEOUT_EN
    check("timeout_cycle", 64'(first_k), 64'd16);
    check("timeout_pulses", 64'(pulses), 64'd1);
    wait_done();
    check("timeout_no_write", {32'd0, regs}, 64'h5C00_0011);
`else
    check("timeout_pulses", 64'(pulses), 64'd0);
    exp_q.push_back(8'hA5);
    send_byte(8'h22);
    wait_done();
    check("late_write", {32'd0, regs}, 64'h5C00_2211);
`endif

    // Reset while in WAIT_DATA
    send_byte(8'h82);
    repeat (2) @(posedge clk);
    #1 i_reset_n = 1'b0;
    #1;
    check("midreset_regs", {32'd0, regs}, 64'd0);
    check("midreset_tx_data", {56'd0, tx_data}, 64'd0);
    check("midreset_overrun", {63'd0, overrun}, 64'd0);
    check("midreset_tx_rdy", {63'd0, tx_rdy}, 64'd0);
    @(posedge clk); #1 i_reset_n = 1'b1;
    exp_q.push_back(8'h00);
    send_byte(8'h01);
    wait_done();
    check("post_reset_regs", {32'd0, regs}, 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/uart_reg_responder.md
# uart_reg_responder

UART-side register-access responder: consumes the byte stream produced by the UART receiver, decodes single-byte read/write commands against a local register file, and returns one response byte per command to the UART transmitter. It is the device end of the host-to-device UART link; it sits between `UartRx` (bytes in) and `UartTx` (bytes out) and exposes the register file as a flat output bus.

## Interface

- `WIDTH_DATA`, 8: UART byte width; fixed at 8 for the command encoding; other values unsupported.
- `NUM_REGS`, 16: register count, 1..16.
- `ACK_BYTE`, 8'hA5: response to an accepted write.
- `NAK_BYTE`, 8'h5A: response to a malformed or out-of-range command.
- `TIMEOUT_CYCLES`, 1024: inter-byte timeout in `i_clk` cycles, ≥2; used only when the timeout macro is defined.

- `i_clk` in 1: single clock; all logic on rising edge.
- `i_reset_n` in 1: reset; **asynchronous, active-low**.
- `iv_rx_data` in 8: received byte; valid when `i_rx_data_ready` is high.
- `i_rx_data_ready` in 1: one-cycle strobe per received byte.
- `ov_tx_data` out 8: response byte to the transmitter.
- `o_tx_data_ready` out 1: one-cycle strobe loading `ov_tx_data` into the transmitter.
- `i_tx_busy` in 1: transmitter busy.
- `ov_regs` out `NUM_REGS*8`: register file; reg k at bits [8k+7:8k].
- `o_overrun` out 1: sticky; a byte arrived while a response was pending.
- `o_timeout` out 1: one-cycle strobe on write abort by timeout.

## Operation

- Command byte: bit7 = 1 write / 0 read; bits6:4 must be 0; bits3:0 = address.
- Invalid command: bits6:4 ≠ 0 or address ≥ `NUM_REGS` → `NAK_BYTE`. For an invalid write, no data byte is consumed.
- Read: respond with the current register value.
- Write: the next received byte is the data. Register updated, then `ACK_BYTE` sent.
- FSM states:
  - IDLE: on a valid write → WAIT_DATA. On a read or invalid command → SEND.
  - WAIT_DATA: on a data byte → write register, then SEND.
  - SEND: pulse `o_tx_data_ready` only while `i_tx_busy` is low, then → WAIT_TX.
  - WAIT_TX: wait for `i_tx_busy` high, then low → IDLE.
- Bytes strobed in SEND or WAIT_TX are discarded and set `o_overrun`. `o_overrun` is cleared only by reset.
- Register writes occur only in WAIT_DATA. Reads sample the register in the command-strobe cycle.

## Timing

- Reset values:
  - Registers all 0; `ov_tx_data` = 0; `o_tx_data_ready` = 0.
  - `o_overrun` = 0; `o_timeout` = 0; state IDLE.
- Reset mid-transaction: immediate return to IDLE. Any pending response is dropped and a partial write is lost.
- Read: command strobe in cycle N → `o_tx_data_ready` high in N+1 when `i_tx_busy` is low, otherwise in the first cycle after `i_tx_busy` falls.
- Write: data strobe in cycle M → `ov_regs` shows the new value from M+1; ACK strobe at M+1 under the same busy rule.
- `ov_tx_data` is stable from the strobe cycle until the next response.
- `o_tx_data_ready` is exactly one cycle wide.
- A strobe arriving in the same cycle SEND is entered is treated as an overrun.

## Configuration

- `UART_REG_RESP_TIMEOUT_EN` defined:
  - A counter runs in WAIT_DATA and is cleared on entry.
  - If `TIMEOUT_CYCLES` elapse with no data strobe: → IDLE, no write, no response, `o_timeout` pulses one cycle.
  - A data strobe in the final cycle wins over the timeout.
- Macro undefined: WAIT_DATA waits indefinitely; `o_timeout` is tied 0; no counter logic.

## Test plan

- Write: 0x83 then 0x5C → one ACK strobe with `ov_tx_data`=0xA5; reg 3 = 0x5C; other registers remain 0.
- Read: after the write, 0x03 → one strobe with `ov_tx_data`=0x5C; registers unchanged.
- Invalid commands:
  - 0x15 → NAK 0x5A.
  - With `NUM_REGS`=4, 0x86 → NAK 0x5A; the next byte 0x02 is treated as a fresh read command.
- Backpressure and overrun: hold `i_tx_busy` high, send 0x00 then 0x01 → one response after busy falls; `o_overrun`=1; the second byte is dropped.
- Timeout (macro on, `TIMEOUT_CYCLES`=16): send 0x81 with no data → `o_timeout` pulse at cycle 16; reg 1 stays 0; no tx strobe.
- Reset: assert `i_reset_n` low in WAIT_DATA → all outputs 0 immediately; after release, 0x01 reads 0x00.
